// File: rtl/switch_pkg.sv
// Shared types and constants for the switch datapath: ingress FSM states,
// terminator encoding, header destination field and input RAM geometry.
package switch_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RAM_AW    = 12;
  localparam int unsigned NUM_PORTS = 4;

  localparam logic [WORD_W-1:0] EOP_WORD = 32'h0000_0000;

  // Destination port field inside a packet header word
  localparam int unsigned DPORT_LSB = 0;
  localparam int unsigned DPORT_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    TERM,
    FULL
  } ing_state_t;

endpackage

// File: rtl/ingress_packet_writer_if.sv
// Valid/ready word stream from the port MAC into the ingress packet writer.
interface ingress_packet_writer_if;
  import switch_pkg::*;

  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/ingress_word_sanitizer.sv
// Combinational zero check: words equal to the terminator are replaced by
// ZERO_SUBST, and zero_hit flags the substitution.
module ingress_word_sanitizer
  import switch_pkg::*;
#(
  parameter logic [WORD_W-1:0] ZERO_SUBST = 32'h0000_0001
) (
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out,
  output logic              zero_hit
);

  always_comb begin
    zero_hit = (word_in == EOP_WORD);
    word_out = zero_hit ? ZERO_SUBST : word_in;
  end

endmodule

// File: rtl/ingress_packet_writer.sv
// Writes MAC packets into the per-port input RAM with a zero terminator and
// publishes the committed write address. Define INGRESS_STORE_FORWARD_EN to
// publish only complete packets instead of cut-through.
module ingress_packet_writer
  import switch_pkg::*;
#(
  parameter int unsigned       DEPTH      = 4096,
  parameter logic [WORD_W-1:0] ZERO_SUBST = 32'h0000_0001,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ingress_packet_writer_if.slave s,
  output logic                 ram_we,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [WORD_W-1:0]    ram_data,
  output logic [RAM_AW-1:0]    input_ram_wr_add,
  output logic                 full,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_zero_cnt,
  output logic                 trunc
);

  localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(DEPTH - 1);
  localparam logic [RAM_AW-1:0] PRE_LAST  = RAM_AW'(DEPTH - 2);

  ing_state_t        state, state_n;
  logic [RAM_AW-1:0] ptr;
  logic              ready_c;
  logic              accept;
  logic              term_we;
  logic              trunc_set;
  logic [WORD_W-1:0] clean_word;
  logic              zero_hit;

  ingress_word_sanitizer #(
    .ZERO_SUBST(ZERO_SUBST)
  ) u_sanitizer (
    .word_in (s.s_data),
    .word_out(clean_word),
    .zero_hit(zero_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ready_c   = 1'b0;
    term_we   = 1'b0;
    trunc_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (ptr > PRE_LAST) begin
          state_n = FULL;
        end else begin
          ready_c = 1'b1;
          if (s.s_valid) state_n = s.s_last ? TERM : PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Out of room: close the packet; the rest of it stays backpressured
        if (ptr == LAST_ADDR) begin
          state_n   = TERM;
          trunc_set = 1'b1;
        end else begin
          ready_c = 1'b1;
          if (s.s_valid && s.s_last) state_n = TERM;
        end
      end
      TERM: begin
        term_we = 1'b1;
        state_n = (ptr >= PRE_LAST) ? FULL : IDLE;
      end
      FULL: state_n = FULL;
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so the handshake is idle while rst_n is held low
  assign s.s_ready = ready_c & rst_n;
  assign accept    = s.s_valid & s.s_ready;
  assign full      = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ptr      <= '0;
    end else if (accept || term_we) begin
      ram_we   <= 1'b1;
      ram_addr <= ptr;
      ram_data <= term_we ? EOP_WORD : clean_word;
      if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
    end else begin
      ram_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt      <= '0;
      err_zero_cnt <= '0;
      trunc        <= 1'b0;
    end else begin
      if (term_we) pkt_cnt <= pkt_cnt + 1'b1;
      if (accept && zero_hit && (err_zero_cnt != '1))
        err_zero_cnt <= err_zero_cnt + 1'b1;
      if (trunc_set) trunc <= 1'b1;
    end
  end

`ifdef INGRESS_STORE_FORWARD_EN
  logic pub_pending;

  // Publish one cycle after the terminator write, so ptr already covers it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pub_pending      <= 1'b0;
      input_ram_wr_add <= '0;
    end else begin
      pub_pending <= term_we;
      if (pub_pending) input_ram_wr_add <= ptr;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) input_ram_wr_add <= '0;
    else        input_ram_wr_add <= ptr;
  end
`endif

endmodule
